// File: rtl/sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor datapath.
package sub_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

  // Full-subtractor borrow; kept here so an adder/subtractor mode can reuse it.
  function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
    return (~x & y) | (~(x ^ y) & bi);
  endfunction

endpackage

// File: rtl/serial_sub_unit_if.sv
// Start/busy/done handshake plus operand and result bus for serial_sub_unit.
interface serial_sub_unit_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, zero, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, zero, ovf
  );
endinterface

// File: rtl/fs_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bi, bo = borrow out.
module fs_cell
  import sub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = fs_borrow(x, y, bi);

endmodule

// File: rtl/serial_sub_unit.sv
// Bit-serial ripple subtractor: one full-subtractor step per clock, LSB first,
// with registered diff/bout/zero/ovf published when the operation completes.
module serial_sub_unit
  import sub_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  serial_sub_unit_if.slave   bus
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   res_sr;
  logic               br;
  logic               a_msb;
  logic               b_msb;

  logic               d_bit;
  logic               bo_bit;
  logic [WIDTH-1:0]   res_nxt;
  logic               last_bit;

  fs_cell u_fs (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (br),
    .d  (d_bit),
    .bo (bo_bit)
  );

  // Result fills from the MSB end so the final bit lands in place.
  assign res_nxt  = {d_bit, res_sr[WIDTH-1:1]};
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      br       <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.diff <= '0;
      bus.bout <= 1'b0;
      bus.zero <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr     <= bus.a;
            b_sr     <= bus.b;
            br       <= bus.bin;
            a_msb    <= bus.a[WIDTH-1];
            b_msb    <= bus.b[WIDTH-1];
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nxt;
          br     <= bo_bit;
          cnt    <= cnt + CNT_W'(1);
          // Flags use the operand signs captured at start, not the shifted copies.
          if (last_bit) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.diff <= res_nxt;
            bus.bout <= bo_bit;
            bus.zero <= (res_nxt == '0);
            bus.ovf  <= (a_msb ^ b_msb) & (a_msb ^ res_nxt[WIDTH-1]);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_unit.sv
// Directed and exhaustive self-checking bench for serial_sub_unit (WIDTH=4).
module tb_serial_sub_unit;

  localparam int unsigned W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_sub_unit_if #(.WIDTH(W)) bus ();

  serial_sub_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one op from IDLE and check latency, busy length and all result flags.
  task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_, input logic tbin,
                       input logic [3:0] e_diff, input logic e_bout,
                       input logic e_zero, input logic e_ovf, input string name);
    int k;
    int busy_cnt;
    bit got;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_;
    bus.bin   = tbin;
    @(posedge clk);
    k = 0; busy_cnt = 0; got = 1'b0;
    while (k < 20 && !got) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        bus.start = 1'b0;
        bus.a     = ~ta;
        bus.b     = ~tb_;
        bus.bin   = ~tbin;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) got = 1'b1;
    end
    checks++;
    if (got !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles", name, k);
    end
    checks++;
    if (k !== 5) begin
      errors++;
      $display("FAIL %s latency: got %0d expected 5", name, k);
    end
    checks++;
    if (busy_cnt !== 4) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected 4", name, busy_cnt);
    end
    checks++;
    if (bus.diff !== e_diff) begin
      errors++;
      $display("FAIL %s diff: got %b expected %b", name, bus.diff, e_diff);
    end
    checks++;
    if (bus.bout !== e_bout) begin
      errors++;
      $display("FAIL %s bout: got %b expected %b", name, bus.bout, e_bout);
    end
    checks++;
    if (bus.zero !== e_zero) begin
      errors++;
      $display("FAIL %s zero: got %b expected %b", name, bus.zero, e_zero);
    end
    checks++;
    if (bus.ovf !== e_ovf) begin
      errors++;
      $display("FAIL %s ovf: got %b expected %b", name, bus.ovf, e_ovf);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: got %b expected 0", name, bus.done);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.diff, bus.bout, bus.zero, bus.ovf} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000000",
               {bus.busy, bus.done, bus.diff, bus.bout, bus.zero, bus.ovf});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_op(4'b0111, 4'b0011, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, "basic_7m3");
    do_op(4'b0011, 4'b0111, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b0, "borrow_3m7");
    do_op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, "bin_0m0m1");
    do_op(4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b1, "ovf_8m1");
    do_op(4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, "zero_5m5");
  endtask

  task automatic test_start_while_busy();
    int dones;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'b0111; bus.b = 4'b0011; bus.bin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'b1111; bus.b = 4'b0000;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL busy_start_dones: got %0d expected 1", dones);
    end
    checks++;
    if (bus.diff !== 4'b0100) begin
      errors++;
      $display("FAIL busy_start_diff: got %b expected 0100", bus.diff);
    end
  endtask

  task automatic test_reset_mid_op();
    int dones;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'b1111; bus.b = 4'b0001; bus.bin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.diff, bus.bout, bus.zero, bus.ovf} !== 9'b0) begin
      errors++;
      $display("FAIL midop_reset_outputs: got %b expected 000000000",
               {bus.busy, bus.done, bus.diff, bus.bout, bus.zero, bus.ovf});
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL midop_no_done: got %0d expected 0", dones);
    end
    do_op(4'b1001, 4'b0100, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b1, "after_reset_9m4");
  endtask

  // All 512 {a,b,bin} combinations with start held high.
  task automatic test_back_to_back();
    int k;
    int ndone;
    int ai, bi, ci, sa, sb, s;
    logic [3:0] e_diff;
    logic e_bout, e_ovf, e_zero;
    bit got;
    ndone = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 4'd0; bus.b = 4'd0; bus.bin = 1'b0;
    for (int i = 0; i < 512; i++) begin
      ai = (i >> 5) & 15;
      bi = (i >> 1) & 15;
      ci = i & 1;
      k = 0; got = 1'b0;
      while (k < 20 && !got) begin
        @(negedge clk);
        k++;
        if (bus.done) got = 1'b1;
      end
      checks++;
      if (got !== 1'b1 || k !== ((i == 0) ? 5 : 6)) begin
        errors++;
        $display("FAIL b2b_spacing op %0d: got %0d cycles (done=%b) expected %0d",
                 i, k, got, (i == 0) ? 5 : 6);
      end
      if (got) ndone++;
      e_diff = 4'((ai - bi - ci) & 15);
      e_bout = (ai < bi + ci);
      sa = (ai >= 8) ? ai - 16 : ai;
      sb = (bi >= 8) ? bi - 16 : bi;
      s  = sa - sb - ci;
      e_ovf  = (s < -8) || (s > 7);
      e_zero = (e_diff == 4'd0);
      checks++;
      if ({bus.diff, bus.bout, bus.zero, bus.ovf} !== {e_diff, e_bout, e_zero, e_ovf}) begin
        errors++;
        $display("FAIL b2b_result a=%0d b=%0d bin=%0d: got diff=%b bout=%b zero=%b ovf=%b expected diff=%b bout=%b zero=%b ovf=%b",
                 ai, bi, ci, bus.diff, bus.bout, bus.zero, bus.ovf,
                 e_diff, e_bout, e_zero, e_ovf);
      end
      if (i < 511) begin
        bus.a   = 4'(((i + 1) >> 5) & 15);
        bus.b   = 4'(((i + 1) >> 1) & 15);
        bus.bin = 1'((i + 1) & 1);
      end else begin
        bus.start = 1'b0;
      end
    end
    checks++;
    if (ndone !== 512) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d expected 512", ndone);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_sub_unit.md
Name: serial_sub_unit

Overview:
Bit-serial ripple subtractor, the inverse operation of the 4-bit ripple-carry adder. It computes DIFF = A − B − Bin one bit per clock through a single full-subtractor cell. It uses a start/busy/done handshake so it can sit behind a simple controller in the ALU datapath. Registered outputs are `diff`, borrow-out, zero and signed-overflow flags.

Parameters:
- WIDTH, 4, operand/result width in bits (≥2).
- CNT_W, $clog2(WIDTH)+1, width of the internal bit counter (derived; do not override).

Ports:
- clk    input   1      rising-edge clock.
- rst    input   1      asynchronous active-high reset.
- start  input   1      request; sampled only in IDLE.
- a      input   WIDTH  minuend; captured on accepted start.
- b      input   WIDTH  subtrahend; captured on accepted start.
- bin    input   1      borrow-in; captured on accepted start.
- busy   output  1      high while bits are being processed.
- done   output  1      one-cycle pulse; results valid from this cycle.
- diff   output  WIDTH  result, (a − b − bin) mod 2^WIDTH.
- bout   output  1      borrow-out; 1 iff a < b + bin, unsigned.
- zero   output  1      diff == 0.
- ovf    output  1      two's-complement overflow of a − b − bin.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, counter=0, shift registers=0, borrow=0. Outputs: busy=0, done=0, diff=0, bout=0, zero=0, ovf=0.
- States:
  - IDLE: start=1 at an edge loads a, b and bin into shift/borrow registers, clears the counter and moves to SHIFT. start=0 stays in IDLE.
  - SHIFT: busy=1. Each cycle:
    - d = a_lsb ^ b_lsb ^ br
    - br' = (~a_lsb & b_lsb) | (~(a_lsb ^ b_lsb) & br)
    - d shifts into the result register MSB-first-fill (right shift); the a/b registers shift right; the counter increments.
    - When the counter reaches WIDTH−1, go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle. Next state is IDLE unconditionally.
- Output update: diff, bout, zero and ovf update at the edge entering DONE and hold until the next entry to DONE or reset. They do not change during SHIFT.
- Flag rules:
  - ovf = (a_msb ^ b_msb) & (a_msb ^ diff_msb), using the captured operands.
  - zero is computed on the final diff.
  - bout is the final borrow.
- Latency: start accepted at edge N → done high in cycle N+WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- start while busy, or in DONE: ignored. It is not queued and the operands are not re-sampled.
- start held continuously: a new operation is accepted on each return to IDLE.
- Operand inputs may change freely after the accepting edge.
- Reset mid-operation: immediate return to IDLE with all outputs cleared. No done pulse is produced.
- No combinational path from any input to any output; all outputs are registers.

Decomposition:
- Package sub_pkg:
  - state typedef {IDLE, SHIFT, DONE}, 2-bit encoding.
  - localparam encodings for these states.
  - Function for the full-subtractor borrow equation, shared with a future adder/subtractor mode.
- Sub-module fs_cell: combinational 1-bit full subtractor (x, y, bi → d, bo), instantiated once in the datapath. It is the counterpart to the adder's full-adder cell.

Test Plan (WIDTH=4):
- a=0111, b=0011, bin=0, start pulse → done at cycle +5; diff=0100, bout=0, zero=0, ovf=0; busy high for exactly 4 cycles.
- a=0011, b=0111, bin=0 → diff=1100, bout=1, ovf=0. Then a=0000, b=0000, bin=1 → diff=1111, bout=1, zero=0.
- a=1000, b=0001, bin=0 → diff=0111, ovf=1, bout=0. Then a=0101, b=0101, bin=0 → diff=0000, zero=1, bout=0.
- Start accepted with a=0111, b=0011; during SHIFT, pulse start with a=1111, b=0000 → first result 0100 only; no second done; outputs hold 0100 until the next accepted start.
- Assert rst two cycles into SHIFT → busy, done and all outputs go to 0 immediately without a clock edge. After release, a fresh op (1001 − 0100) → diff=0101.
- Exhaustive: iterate {a,b,bin} over all 512 combinations back-to-back with start held high. Check each done against (a−b−bin) mod 16, the bout compare, and the signed-range ovf. Expect 512 done pulses, each 6 cycles apart.
